// File: rtl/hack_pc_if.sv
// Hack PC stage bus: ALU flags, jump field and A-register target going in;
// instruction address and status coming back out.
interface hack_pc_if #(
  parameter int unsigned WIDTH = 16
);
  logic             en;
  logic             is_c;
  logic [2:0]       jbits;
  logic             zr;
  logic             ng;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] pc;
  logic             jumped;
  logic             halted;

  // Datapath side: supplies instruction fields and flags, observes the PC.
  modport master (
    output en, is_c, jbits, zr, ng, a_in,
    input  pc, jumped, halted
  );

  // PC stage side.
  modport slave (
    input  en, is_c, jbits, zr, ng, a_in,
    output pc, jumped, halted
  );
endinterface

// File: rtl/hack_pc.sv
// Hack CPU program counter: conditional jump to A, increment, or hold, with
// a latched HALT on the unconditional jump-to-self end-of-program idiom.
module hack_pc #(
  parameter int unsigned          WIDTH    = 16,
  parameter logic [WIDTH-1:0]     RESET_PC = '0
) (
  input  logic        clk,
  input  logic        rst_n,
  hack_pc_if.slave    bus
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             jumped_q, jumped_d;

  logic             j_lt, j_eq, j_gt;
  logic             take;
  logic             self_halt;

  // Jump decode; flags are taken literally, so zr=ng=1 can satisfy j1 and j2.
  always_comb begin
    j_lt      = bus.jbits[2] & bus.ng;
    j_eq      = bus.jbits[1] & bus.zr;
    j_gt      = bus.jbits[0] & ~bus.ng & ~bus.zr;
    take      = bus.is_c & (j_lt | j_eq | j_gt);
    self_halt = bus.is_c & (bus.jbits == 3'b111) & (bus.a_in == pc_q);
  end

  // Next-state and next-PC selection; jump wins over increment.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    jumped_d = 1'b0;
    unique case (state_q)
      RUN: begin
        if (bus.en) begin
          if (take) begin
            pc_d     = bus.a_in;
            jumped_d = 1'b1;
            if (self_halt) begin
              state_d = HALT;
            end
          end else begin
            pc_d = pc_q + WIDTH'(1);
          end
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State, PC and jump-pulse registers; reset takes effect immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      jumped_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      jumped_q <= jumped_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    bus.pc     = pc_q;
    bus.jumped = jumped_q;
    bus.halted = (state_q == HALT);
  end

endmodule

// File: tb/tb_hack_pc.sv
// Directed bench for hack_pc: increment, conditional jumps, enable gating,
// wrap, illegal flags, halt entry/freeze and asynchronous reset exit.
module tb_hack_pc;

  logic clk;
  logic rst_n;
  int unsigned tests;
  int unsigned fails;

  hack_pc_if #(.WIDTH(16)) bus ();

  hack_pc #(.WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic status(input string tag, input logic [15:0] epc,
                        input logic ejmp, input logic ehlt);
    check({tag, ".pc"}, bus.pc, epc);
    check({tag, ".jumped"}, {15'd0, bus.jumped}, {15'd0, ejmp});
    check({tag, ".halted"}, {15'd0, bus.halted}, {15'd0, ehlt});
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic is_c, input logic [2:0] jb,
                       input logic zr, input logic ng, input logic [15:0] a);
    bus.en    = en;
    bus.is_c  = is_c;
    bus.jbits = jb;
    bus.zr    = zr;
    bus.ng    = ng;
    bus.a_in  = a;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 16'h0000);
    #2;
    status("reset", 16'h0000, 1'b0, 1'b0);
    #10 rst_n = 1'b1;  // t=12, between edges
    #4;                // t=16, after edge at 15 which saw rst_n=1 and en=0
    status("post_reset_hold", 16'h0000, 1'b0, 1'b0);

    // Plain increments with A-instructions.
    drive(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 16'h0000);
    for (int i = 1; i <= 5; i++) begin
      step();
      status($sformatf("inc%0d", i), 16'(i), 1'b0, 1'b0);
    end

    // Unconditional jump elsewhere to reach pc=3.
    drive(1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 16'h0003);
    step(); status("jmp_to_3", 16'h0003, 1'b1, 1'b0);

    // JEQ taken with zr=1.
    drive(1'b1, 1'b1, 3'b010, 1'b1, 1'b0, 16'h0100);
    step(); status("jeq_taken", 16'h0100, 1'b1, 1'b0);

    // JEQ not taken with positive result.
    drive(1'b1, 1'b1, 3'b010, 1'b0, 1'b0, 16'h0100);
    step(); status("jeq_not_taken", 16'h0101, 1'b0, 1'b0);

    // Enable gating: taken jump presented with en=0 must not move pc.
    drive(1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 16'h0007);
    step(); status("jmp_to_7", 16'h0007, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 16'h0020);
    for (int i = 0; i < 3; i++) begin
      step();
      status($sformatf("en_low%0d", i), 16'h0007, 1'b0, 1'b0);
    end
    bus.en = 1'b1;
    step(); status("en_high_jump", 16'h0020, 1'b1, 1'b0);

    // JGT with negative result is not taken.
    drive(1'b1, 1'b1, 3'b001, 1'b0, 1'b1, 16'h0999);
    step(); status("jgt_neg", 16'h0021, 1'b0, 1'b0);
    // JLT with negative result is taken.
    drive(1'b1, 1'b1, 3'b100, 1'b0, 1'b1, 16'h0999);
    step(); status("jlt_neg", 16'h0999, 1'b1, 1'b0);

    // Wrap from 0xFFFF to 0.
    drive(1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 16'hFFFF);
    step(); status("jmp_ffff", 16'hFFFF, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 16'h0000);
    step(); status("wrap", 16'h0000, 1'b0, 1'b0);

    // Illegal flags zr=ng=1: j3 term is dead, j1 term fires.
    drive(1'b1, 1'b1, 3'b001, 1'b1, 1'b1, 16'h0055);
    step(); status("illegal_jgt", 16'h0001, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 3'b100, 1'b1, 1'b1, 16'h0055);
    step(); status("illegal_jlt", 16'h0055, 1'b1, 1'b0);

    // A-instruction with self-jump-looking fields: increment, no halt.
    drive(1'b1, 1'b0, 3'b111, 1'b0, 1'b0, 16'h0055);
    step(); status("a_instr_self", 16'h0056, 1'b0, 1'b0);

    // Conditional self-jump reloads pc but never halts.
    drive(1'b1, 1'b1, 3'b010, 1'b1, 1'b0, 16'h0056);
    step(); status("cond_self", 16'h0056, 1'b1, 1'b0);

    // Halt entry at 0x0010.
    drive(1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 16'h0010);
    step(); status("jmp_to_10", 16'h0010, 1'b1, 1'b0);
    step(); status("halt_entry", 16'h0010, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 16'h0040);
    step(); status("halt_frozen", 16'h0010, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 16'h0000);
    step(); status("halt_ignore_inc", 16'h0010, 1'b0, 1'b1);

    // Asynchronous reset out of HALT, checked before the next edge.
    rst_n = 1'b0;
    #1;
    status("async_reset", 16'h0000, 1'b0, 1'b0);
    #2 rst_n = 1'b1;   // still well clear of the next edge
    step(); status("after_reset_inc", 16'h0001, 1'b0, 1'b0);

    // Self-jump at the top address halts without wrapping.
    drive(1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 16'hFFFF);
    step(); status("top_jmp", 16'hFFFF, 1'b1, 1'b0);
    step(); status("top_halt", 16'hFFFF, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 16'h0000);
    step(); status("top_frozen", 16'hFFFF, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
